// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Bundles the serial line and the received-byte outputs of
//            uart_rx.
//   rx         serial line, idle high (driven by the line side)
//   data       last correctly framed byte
//   ready      one-clock pulse, data just updated
//   frame_err  one-clock pulse, stop bit sampled low
//   busy       receiver is inside a frame
// Modports : master - line driver / byte consumer
//            slave  - the receiver itself
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input data, ready, frame_err, busy);
    modport slave  (input rx, output data, ready, frame_err, busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, 16x oversampling, 3-sample majority vote.
//            Emits the byte with a one-clock ready strobe. A low stop bit
//            gives a one-clock frame_err strobe and the receiver then waits
//            for the line to return high before hunting for a new start.
// Ports    : clk    system clock, rising edge
//            rst_n  asynchronous active-low reset
//            bus    uart_rx_if.slave (rx in; data/ready/frame_err/busy out)
// Params   : CLK_FREQ  system clock in Hz
//            BAUD      line rate; divider = CLK_FREQ/(BAUD*16), must be >= 1
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 62500000,
    parameter int BAUD     = 115200
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int                 c_DIV      = CLK_FREQ / (BAUD * 16);
    localparam int                 c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_scnt;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic               r_s7;
    logic               r_s8;
    logic [7:0]         r_data;
    logic               r_ready;
    logic               r_ferr;
    logic               r_busy;

    logic w_tick;
    logic w_vote_now;
    logic w_vote;

    // The divider is frozen in IDLE so the first tick of a frame lands a
    // fixed number of clocks after the start edge is seen.
    assign w_tick     = (r_state != S_IDLE) && (r_div == c_DIV_LAST);
    assign w_vote_now = w_tick && (r_scnt == 4'd9);
    // Samples at scnt 7 and 8 were captured on earlier ticks; the scnt 9
    // sample is the live synchronised line.
    assign w_vote     = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_div    <= '0;
            r_scnt   <= 4'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_s7     <= 1'b1;
            r_s8     <= 1'b1;
            r_data   <= 8'h00;
            r_ready  <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;

            if (r_state == S_IDLE || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_tick) begin
                r_scnt <= r_scnt + 4'd1;
                if (r_scnt == 4'd7) r_s7 <= r_sync2;
                if (r_scnt == 4'd8) r_s8 <= r_sync2;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_scnt  <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_vote_now) begin
                        if (w_vote) begin
                            // Start bit did not hold: treat as a glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_vote_now) begin
                        r_shift  <= {w_vote, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_vote_now) begin
                        if (w_vote) begin
                            // Back to IDLE mid stop bit so a following start
                            // edge is caught without an idle gap.
                            r_data  <= r_shift;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // A held-low line must not look like a stream of starts.
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = r_data;
    assign bus.ready     = r_ready;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire
